// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing controller: ALUCtrl op codes,
// FSM state encoding and the default datapath width.
package alu_share_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // ALUCtrl encoding understood by the shared ALU
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_MUL = 3'b100
  } alu_op_e;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Codes above ALU_MUL have no ALU function assigned
  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op > 3'b100);
  endfunction

  // Multiply gets the stretched evaluation window
  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == 3'b100);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and on a tie
// the requester that did not win last time is granted. Purely combinational.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // Grant selection from the current valids and the previous winner
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (valid0_i && valid1_i) begin
      if (last_grant_i) begin
        gnt0_o = 1'b1;
      end else begin
        gnt1_o = 1'b1;
      end
    end else if (valid0_i) begin
      gnt0_o = 1'b1;
    end else if (valid1_i) begin
      gnt1_o = 1'b1;
    end else begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. Accepted operands are
// held on alu_* while the ALU evaluates (MUL_CYCLES cycles for mul, one
// otherwise); the captured result is returned with its owner ID over a
// valid/ready response channel.
// Optional build macro ALU_SHARE_CTRL_ERR_EN: adds rsp_err_o and answers
// illegal op codes immediately with an error response instead of using the ALU.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_data1_i,
  input  logic [WIDTH-1:0] req0_data2_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_data1_i,
  input  logic [WIDTH-1:0] req1_data2_i,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_zero_o
`ifdef ALU_SHARE_CTRL_ERR_EN
  ,
  output logic             rsp_err_o
`endif
);

  // Counter only needs to hold MUL_CYCLES-1
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_data1_q, alu_data1_d;
  logic [WIDTH-1:0]   alu_data2_q, alu_data2_d;
  logic [2:0]         alu_ctrl_q, alu_ctrl_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_zero_q, rsp_zero_d;
`ifdef ALU_SHARE_CTRL_ERR_EN
  logic               rsp_err_q, rsp_err_d;
`endif

  logic               gnt0_s, gnt1_s;
  logic               accept_s;
  logic               sel_id_s;
  logic [2:0]         sel_op_s;
  logic [WIDTH-1:0]   sel_data1_s;
  logic [WIDTH-1:0]   sel_data2_s;

  rr_arb2 u_arb (
    .valid0_i     (req0_valid_i),
    .valid1_i     (req1_valid_i),
    .last_grant_i (last_grant_q),
    .gnt0_o       (gnt0_s),
    .gnt1_o       (gnt1_s)
  );

  // Requesters are only offered a slot while the ALU is free
  assign req0_ready_o = (state_q == IDLE) && gnt0_s;
  assign req1_ready_o = (state_q == IDLE) && gnt1_s;
  assign accept_s     = req0_ready_o || req1_ready_o;

  // Operand mux for the granted requester
  assign sel_id_s    = gnt1_s;
  assign sel_op_s    = gnt1_s ? req1_op_i    : req0_op_i;
  assign sel_data1_s = gnt1_s ? req1_data1_i : req0_data1_i;
  assign sel_data2_s = gnt1_s ? req1_data2_i : req0_data2_i;

  // Next-state and next-output computation for the sequencing FSM
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
`ifdef ALU_SHARE_CTRL_ERR_EN
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          last_grant_d = sel_id_s;
          id_d         = sel_id_s;
          alu_data1_d  = sel_data1_s;
          alu_data2_d  = sel_data2_s;
`ifdef ALU_SHARE_CTRL_ERR_EN
          if (op_is_illegal(sel_op_s)) begin
            // No ALU function: answer at once, leave the ALU control alone
            rsp_valid_d = 1'b1;
            rsp_id_d    = sel_id_s;
            rsp_data_d  = {WIDTH{1'b0}};
            rsp_zero_d  = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            alu_ctrl_d = sel_op_s;
            cnt_d      = op_is_mul(sel_op_s) ? CNT_MUL : CNT_ZERO;
            state_d    = EXEC;
          end
`else
          alu_ctrl_d = sel_op_s;
          cnt_d      = op_is_mul(sel_op_s) ? CNT_MUL : CNT_ZERO;
          state_d    = EXEC;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = alu_data_i;
          rsp_zero_d  = alu_zero_i;
`ifdef ALU_SHARE_CTRL_ERR_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= CNT_ZERO;
      alu_data1_q  <= {WIDTH{1'b0}};
      alu_data2_q  <= {WIDTH{1'b0}};
      alu_ctrl_q   <= 3'b000;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= {WIDTH{1'b0}};
      rsp_zero_q   <= 1'b0;
`ifdef ALU_SHARE_CTRL_ERR_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_SHARE_CTRL_ERR_EN
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign alu_data1_o = alu_data1_q;
  assign alu_data2_o = alu_data2_q;
  assign alu_ctrl_o  = alu_ctrl_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_zero_o  = rsp_zero_q;
`ifdef ALU_SHARE_CTRL_ERR_EN
  assign rsp_err_o   = rsp_err_q;
`endif

endmodule
